rect_fill: RTL and testbench



---
 rtl/vga_pkg.sv | 33 +++
 rtl/rect_scan.sv | 53 +++++
 rtl/rect_fill.sv | 139 +++++++++++++
 tb/tb_rect_fill.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// Shared VGA definitions: visible-area and channel defaults, pixel/command types and the
// rectangle-fill FSM state enum.
package vga_pkg;

    localparam int H_VISIBLE_AREA_DEF = 320;
    localparam int V_VISIBLE_AREA_DEF = 240;
    localparam int RED_WIDTH_DEF      = 4;
    localparam int GREEN_WIDTH_DEF    = 4;
    localparam int BLUE_WIDTH_DEF     = 4;
    localparam int COORD_WIDTH_DEF    = 16;

    typedef struct packed {
        logic [RED_WIDTH_DEF-1:0]   red;
        logic [GREEN_WIDTH_DEF-1:0] green;
        logic [BLUE_WIDTH_DEF-1:0]  blue;
    } pixel_t;

    typedef struct packed {
        logic [COORD_WIDTH_DEF-1:0] x;
        logic [COORD_WIDTH_DEF-1:0] y;
        logic [COORD_WIDTH_DEF-1:0] w;
        logic [COORD_WIDTH_DEF-1:0] h;
        pixel_t                     color;
    } rect_cmd_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SETUP = 2'd1,
        FILL  = 2'd2,
        DONE  = 2'd3
    } rect_state_t;

endpackage

// File: rtl/rect_scan.sv
// Column-major scan of a clipped rectangle: y inner, x outer, with an incrementing
// frame-buffer address that jumps to the next column's top at each column end.
module rect_scan #(
    parameter int V_VISIBLE_AREA = 240,
    parameter int COORD_WIDTH    = 16,
    parameter int ADDR_WIDTH     = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  advance,
    input  logic [COORD_WIDTH:0]  w_eff,
    input  logic [COORD_WIDTH:0]  h_eff,
    input  logic [ADDR_WIDTH-1:0] start_addr,
    output logic [ADDR_WIDTH-1:0] addr,
    output logic                  last
);
    import vga_pkg::*;

    logic [COORD_WIDTH:0]  x_left;
    logic [COORD_WIDTH:0]  y_left;
    logic [COORD_WIDTH:0]  y_reload;
    logic [ADDR_WIDTH-1:0] col_jump;

    // Down-counters of remaining columns / rows; terminal count on both marks the last pixel.
    always_ff @(posedge clk) begin
        if (reset) begin
            x_left   <= '0;
            y_left   <= '0;
            y_reload <= '0;
            col_jump <= '0;
            addr     <= '0;
        end else if (start) begin
            x_left   <= w_eff - (COORD_WIDTH+1)'(1);
            y_left   <= h_eff - (COORD_WIDTH+1)'(1);
            y_reload <= h_eff - (COORD_WIDTH+1)'(1);
            col_jump <= ADDR_WIDTH'(V_VISIBLE_AREA) - ADDR_WIDTH'(h_eff) + ADDR_WIDTH'(1);
            addr     <= start_addr;
        end else if (advance) begin
            if (y_left == '0) begin
                y_left <= y_reload;
                x_left <= x_left - (COORD_WIDTH+1)'(1);
                addr   <= addr + col_jump;
            end else begin
                y_left <= y_left - (COORD_WIDTH+1)'(1);
                addr   <= addr + ADDR_WIDTH'(1);
            end
        end
    end

    assign last = (x_left == '0) && (y_left == '0);

endmodule

// File: rtl/rect_fill.sv
// Rectangle fill engine: one command at a time, one frame-buffer write per cycle.
// Define RECT_FILL_CLIP_EN to clip at the visible area; otherwise out-of-bounds commands are rejected.
//
//   state | meaning
//   IDLE  | cmd_ready high, latch command on cmd_valid
//   SETUP | compute clipped bounds and start address
//   FILL  | one pixel write per cycle until the last pixel
//   DONE  | pulse done (and error for a rejected command)
module rect_fill
    import vga_pkg::*;
#(
    parameter int H_VISIBLE_AREA = H_VISIBLE_AREA_DEF,
    parameter int V_VISIBLE_AREA = V_VISIBLE_AREA_DEF,
    parameter int RED_WIDTH      = RED_WIDTH_DEF,
    parameter int GREEN_WIDTH    = GREEN_WIDTH_DEF,
    parameter int BLUE_WIDTH     = BLUE_WIDTH_DEF,
    parameter int COORD_WIDTH    = COORD_WIDTH_DEF,
    parameter int ADDR_WIDTH     = 32,
    parameter int PIXEL_WIDTH    = RED_WIDTH + GREEN_WIDTH + BLUE_WIDTH
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   cmd_valid,
    output logic                   cmd_ready,
    input  logic [COORD_WIDTH-1:0] cmd_x,
    input  logic [COORD_WIDTH-1:0] cmd_y,
    input  logic [COORD_WIDTH-1:0] cmd_w,
    input  logic [COORD_WIDTH-1:0] cmd_h,
    input  logic [PIXEL_WIDTH-1:0] cmd_color,
    output logic                   write_enable,
    output logic [ADDR_WIDTH-1:0]  write_addr,
    output logic [PIXEL_WIDTH-1:0] pixel_in,
    output logic                   busy,
    output logic                   done,
    output logic                   error
);
    localparam int CW1 = COORD_WIDTH + 1;
    localparam logic [CW1-1:0] H_LIM = CW1'(H_VISIBLE_AREA);
    localparam logic [CW1-1:0] V_LIM = CW1'(V_VISIBLE_AREA);

    rect_state_t state, state_nxt;

    logic [COORD_WIDTH-1:0] x_q, y_q, w_q, h_q;
    logic [PIXEL_WIDTH-1:0] color_q;
    logic                   reject_q;

    logic [CW1-1:0]        x_ext, y_ext, x_sum, y_sum, x_end, y_end, w_eff, h_eff;
    logic [ADDR_WIDTH-1:0] start_addr;
    logic                  empty, reject, fill_go, scan_start, scan_advance, scan_last;

    // Bounds are one bit wider than the coordinates so x + w cannot wrap.
    assign x_ext = {1'b0, x_q};
    assign y_ext = {1'b0, y_q};
    assign x_sum = x_ext + {1'b0, w_q};
    assign y_sum = y_ext + {1'b0, h_q};
    assign x_end = (x_sum > H_LIM) ? H_LIM : x_sum;
    assign y_end = (y_sum > V_LIM) ? V_LIM : y_sum;
    assign w_eff = x_end - x_ext;
    assign h_eff = y_end - y_ext;
    assign empty = (w_q == '0) || (h_q == '0) || (x_ext >= H_LIM) || (y_ext >= V_LIM);
`ifdef RECT_FILL_CLIP_EN
    assign reject = 1'b0;
`else
    assign reject = (x_sum > H_LIM) || (y_sum > V_LIM);
`endif
    assign fill_go    = !empty && !reject;
    assign start_addr = ADDR_WIDTH'(x_q) * ADDR_WIDTH'(V_VISIBLE_AREA) + ADDR_WIDTH'(y_q);

    assign scan_start   = (state == SETUP) && fill_go;
    assign scan_advance = (state == FILL) && !scan_last;

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (cmd_valid) state_nxt = SETUP;
            SETUP:   state_nxt = fill_go ? FILL : DONE;
            FILL:    if (scan_last) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        cmd_ready    = (state == IDLE);
        busy         = (state != IDLE);
        write_enable = (state == FILL);
        done         = (state == DONE);
`ifdef RECT_FILL_CLIP_EN
        error        = 1'b0;
`else
        error        = (state == DONE) && reject_q;
`endif
    end

    // pixel_in only moves when a fill starts, so it holds across idle and rejected commands.
    always_ff @(posedge clk) begin
        if (reset) begin
            x_q      <= '0;
            y_q      <= '0;
            w_q      <= '0;
            h_q      <= '0;
            color_q  <= '0;
            reject_q <= 1'b0;
            pixel_in <= '0;
        end else begin
            if (state == IDLE && cmd_valid) begin
                x_q     <= cmd_x;
                y_q     <= cmd_y;
                w_q     <= cmd_w;
                h_q     <= cmd_h;
                color_q <= cmd_color;
            end
            if (state == SETUP) reject_q <= reject;
            if (scan_start)     pixel_in <= color_q;
        end
    end

    rect_scan #(
        .V_VISIBLE_AREA (V_VISIBLE_AREA),
        .COORD_WIDTH    (COORD_WIDTH),
        .ADDR_WIDTH     (ADDR_WIDTH)
    ) u_scan (
        .clk        (clk),
        .reset      (reset),
        .start      (scan_start),
        .advance    (scan_advance),
        .w_eff      (w_eff),
        .h_eff      (h_eff),
        .start_addr (start_addr),
        .addr       (write_addr),
        .last       (scan_last)
    );

endmodule

// File: tb/tb_rect_fill.sv
// Randomized bench for rect_fill against a loop-based model of the clipped pixel list.
// Honours RECT_FILL_CLIP_EN the same way as the design.
module tb_rect_fill;

    localparam int H  = 320;
    localparam int V  = 240;
    localparam int CW = 16;
    localparam int AW = 32;
    localparam int PW = 12;

    logic          clk = 1'b0;
    logic          reset;
    logic          cmd_valid;
    logic          cmd_ready;
    logic [CW-1:0] cmd_x, cmd_y, cmd_w, cmd_h;
    logic [PW-1:0] cmd_color;
    logic          write_enable;
    logic [AW-1:0] write_addr;
    logic [PW-1:0] pixel_in;
    logic          busy, done, error;

    int n_cmp = 0;
    int n_bad = 0;
    logic [AW-1:0] last_addr = '0;
    logic [PW-1:0] last_pix  = '0;

    rect_fill dut (
        .clk          (clk),
        .reset        (reset),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_x        (cmd_x),
        .cmd_y        (cmd_y),
        .cmd_w        (cmd_w),
        .cmd_h        (cmd_h),
        .cmd_color    (cmd_color),
        .write_enable (write_enable),
        .write_addr   (write_addr),
        .pixel_in     (pixel_in),
        .busy         (busy),
        .done         (done),
        .error        (error)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic scramble_inputs();
        cmd_x     = CW'($urandom);
        cmd_y     = CW'($urandom);
        cmd_w     = CW'($urandom);
        cmd_h     = CW'($urandom);
        cmd_color = PW'($urandom);
    endtask

    // Called at a negedge with the engine idle. abort_at > 0 asserts reset in that cycle.
    task automatic run_cmd(input int x, input int y, input int w, input int h,
                           input logic [PW-1:0] c, input int abort_at);
        logic [AW-1:0] q[$];
        bit rej, empty;
        int xe, ye, n;
        q     = {};
        xe    = (x + w > H) ? H : x + w;
        ye    = (y + h > V) ? V : y + h;
        empty = (w == 0) || (h == 0) || (x >= H) || (y >= V);
`ifdef RECT_FILL_CLIP_EN
        rej = 1'b0;
`else
        rej = (x + w > H) || (y + h > V);
`endif
        if (!rej && !empty)
            for (int xi = x; xi < xe; xi++)
                for (int yi = y; yi < ye; yi++)
                    q.push_back(AW'(xi * V + yi));
        n = q.size();

        check_eq("ready_idle", cmd_ready, 1);
        cmd_x = CW'(x); cmd_y = CW'(y); cmd_w = CW'(w); cmd_h = CW'(h); cmd_color = c;
        cmd_valid = 1'b1;
        @(posedge clk);
        for (int k = 1; k <= n + 2; k++) begin
            @(negedge clk);
            if (k == 1) scramble_inputs();
            check_eq("ready_busy", cmd_ready, 0);
            check_eq("busy", busy, 1);
            if (k == 1) begin
                check_eq("we_setup", write_enable, 0);
                check_eq("done_setup", done, 0);
                check_eq("addr_hold", write_addr, last_addr);
                check_eq("pix_hold", pixel_in, last_pix);
            end else if (k <= n + 1) begin
                check_eq("we_fill", write_enable, 1);
                check_eq("addr", write_addr, q[k-2]);
                check_eq("pix", pixel_in, c);
                check_eq("done_fill", done, 0);
                check_eq("err_fill", error, 0);
            end else begin
                if (n > 0) begin
                    last_addr = q[n-1];
                    last_pix  = c;
                end
                check_eq("we_done", write_enable, 0);
                check_eq("done", done, 1);
                check_eq("error", error, rej);
                check_eq("addr_after", write_addr, last_addr);
                check_eq("pix_after", pixel_in, last_pix);
                cmd_valid = 1'b0;
            end
            if (k == abort_at) begin
                reset = 1'b1;
                @(negedge clk);
                check_eq("abort_we", write_enable, 0);
                check_eq("abort_done", done, 0);
                check_eq("abort_busy", busy, 0);
                check_eq("abort_addr", write_addr, 0);
                reset = 1'b0;
                cmd_valid = 1'b0;
                last_addr = '0;
                last_pix  = '0;
                @(negedge clk);
                check_eq("abort_ready", cmd_ready, 1);
                check_eq("abort_nodone", done, 0);
                check_eq("abort_we2", write_enable, 0);
                return;
            end
        end
        @(negedge clk);
        check_eq("ready_back", cmd_ready, 1);
        check_eq("busy_off", busy, 0);
        check_eq("done_off", done, 0);
    endtask

    initial begin
        int x, y, w, h;
        reset = 1'b1;
        cmd_valid = 1'b0;
        cmd_x = '0; cmd_y = '0; cmd_w = '0; cmd_h = '0; cmd_color = '0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check_eq("rst_we", write_enable, 0);
        check_eq("rst_addr", write_addr, 0);
        check_eq("rst_pix", pixel_in, 0);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_done", done, 0);
        check_eq("rst_error", error, 0);
        check_eq("rst_ready", cmd_ready, 1);

        run_cmd(10, 20, 3, 2, 12'hF0F, 0);
        run_cmd(318, 238, 5, 5, 12'hABC, 0);
        run_cmd(5, 5, 0, 7, 12'h123, 0);
        run_cmd(320, 5, 0, 4, 12'h456, 0);
        run_cmd(7, 9, 4, 0, 12'h789, 0);
        run_cmd(315, 0, 5, 240, 12'h5A5, 0);
        run_cmd(0, 0, 320, 240, 12'h000, 0);
        run_cmd(100, 100, 10, 10, 12'h3C3, 40);

        for (int i = 0; i < 40; i++) begin
            x = ($urandom_range(0, 3) == 0) ? $urandom_range(305, 319) : $urandom_range(0, 319);
            y = ($urandom_range(0, 3) == 0) ? $urandom_range(225, 239) : $urandom_range(0, 239);
            w = $urandom_range(0, 12);
            h = $urandom_range(0, 12);
            run_cmd(x, y, w, h, PW'($urandom), 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
